sti_deserializer: RTL and testbench
===================================

# sti_deserializer

Serial-to-parallel receiver placed directly downstream of the STI serial transmitter. It samples the transmitter's `so_data`/`so_valid` pair, rebuilds each 8/16/24/32-bit frame into a 32-bit word, and checks the frame length. It queues good words in a small first-word-fall-through (FWFT) FIFO, which a consumer drains with a valid/ready handshake.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `clk` in 1: clock; all sampling on rising edge.
- `reset` in 1: asynchronous, active-high.
- `si_data` in 1: serial data bit; connect to transmitter `so_data`.
- `si_valid` in 1: frame-active qualifier; connect to transmitter `so_valid`.
- `rd_ready` in 1: consumer accepts head word this cycle.
- `rd_valid` out 1: FIFO non-empty.
- `rd_word` out 32: head word; bit n = nth received bit of the frame; unused upper bits 0.
- `rd_len` out 2: head length code; 0=8, 1=16, 2=24, 3=32 bits.
- `err_len` out 1: one-cycle pulse when a frame is dropped for bad length.
- `overflow` out 1: sticky; set when a good frame is dropped because the FIFO is full.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Receive FSM has two states, IDLE and RECV.
  - IDLE, `si_valid`=1: write `si_data` into shift bit 0, clear the rest of the shift register, set `cnt`=1, go to RECV.
  - RECV, `si_valid`=1: if `cnt`<32, write `si_data` into shift bit `cnt`. Then `cnt`++, saturating at 33. Stay in RECV.
  - RECV, `si_valid`=0 (frame end): evaluate the frame, return to IDLE. `si_data` is ignored while `si_valid`=0.
- Frame evaluation at frame end:
  - `cnt` in {8,16,24,32}: good frame. Push {shift, `cnt`/8-1} into the FIFO if accepted; otherwise drop it and set `overflow`.
  - Any other `cnt`, including 33 (over 32 bits): drop the frame and pulse `err_len`; bits beyond 32 are never stored.
- Push acceptance: push succeeds if `level`<DEPTH, or if `level`==DEPTH and a pop happens in the same cycle (`rd_valid`&`rd_ready`).
- Pop: occurs when `rd_valid`&`rd_ready`. The read pointer advances, and the next entry appears on `rd_word`/`rd_len` the following cycle.
- Simultaneous push and pop: `level` is unchanged; both pointers advance.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `level` is a separate counter.
- With `rd_valid`=0, `rd_word`=0 and `rd_len`=0; the head is gated to zero when empty.
- Consecutive frames must be separated by at least one cycle with `si_valid`=0. That low cycle is the frame terminator. The next frame may start on the very next cycle.

## Timing
- Reset values: `rd_valid`=0, `rd_word`=0, `rd_len`=0, `err_len`=0, `overflow`=0, `level`=0; FSM in IDLE, `cnt`=0, pointers 0.
- Reset mid-frame aborts the frame, pushes nothing and clears the FIFO.
- Bit k of a frame is sampled at the k-th rising edge with `si_valid`=1.
- Frame-end edge: first rising edge with `si_valid`=0 in RECV.
  - `rd_valid`, `level` and `err_len` update at the frame-end edge, i.e. the cycle after the last data bit.
  - Receive latency is therefore 1 clock from the last bit to the word at the FIFO output, when the FIFO was empty.
- `err_len` is high for exactly one cycle after the frame-end edge.
- `overflow` stays high until reset.
- `rd_ready` is sampled at the rising edge; outputs are registered or derived from registered state only, with no combinational path from `rd_ready` to `rd_valid`.
- A frame still in progress when `reset` rises is lost; no partial commit.

## Test plan
- **8-bit frame:** send bits 1,0,1,0,0,1,0,1 then `si_valid`=0, with `rd_ready`=0.
  - Required: `rd_valid`=1 one cycle after the low cycle, `rd_word`=0x000000A5, `rd_len`=0, `level`=1.
  - Then one cycle of `rd_ready`=1 → `rd_valid`=0, `level`=0.
- **32-bit frame:** send 0xDEADBEEF LSB-first.
  - Required: `rd_word`=0xDEADBEEF, `rd_len`=3.
  - Repeat with 24-bit 0x123456 → `rd_len`=2, `rd_word`=0x00123456.
- **Bad lengths:** send a 12-bit frame, then a 40-bit frame.
  - Required: each produces a single-cycle `err_len` pulse; `level` stays 0; `overflow` stays 0.
- **Full FIFO (`DEPTH`=4, `rd_ready`=0):** send five 16-bit frames 0x0001..0x0005.
  - Required: `level`=4, `overflow`=1 after the fifth frame.
  - Drain: words pop in order 0x0001..0x0004 with `rd_len`=1.
- **Push and pop at full:** fill to 4, then hold `rd_ready`=1 during the frame-end edge of an 8-bit frame 0x7E.
  - Required: `level` stays 4, `overflow` stays 0, and 0x7E is the last word popped.
- **Reset mid-frame and pointer wrap:**
  - Assert `reset` after 5 bits of a frame → all outputs 0. A following 8-bit frame 0x3C is received correctly.
  - Then 10 push/pop cycles verify pointer wrap with the data sequence intact.

Source files
------------

// File: rtl/sti_deserializer_if.sv
// Receive-side bundle for the STI deserializer: the serial input pair plus the FWFT read port.
// Read handshake: a word moves when rd_valid && rd_ready at a rising edge; rd_valid never depends on rd_ready.
interface sti_deserializer_if;
   logic        si_data;
   logic        si_valid;
   logic        rd_ready;
   logic        rd_valid;
   logic [31:0] rd_word;
   logic [1:0]  rd_len;

   modport master (output si_data, si_valid, rd_ready, input rd_valid, rd_word, rd_len);
   modport slave  (input si_data, si_valid, rd_ready, output rd_valid, rd_word, rd_len);
endinterface

// File: rtl/sti_deserializer.sv
// STI serial receiver: rebuilds 8/16/24/32-bit frames, drops bad lengths,
// and queues good words in a small first-word-fall-through FIFO.
module sti_deserializer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   sti_deserializer_if.slave        bus,
   output logic                     err_len,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     dbg_recv_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

   state_t        state_q;
   logic [31:0]   shift_q;
   logic [5:0]    cnt_q;
   logic [33:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [LW-1:0] level_q;
   logic          err_len_q;
   logic          overflow_q;

   logic       frame_end;
   logic       len_ok;
   logic       pop;
   logic       push;
   logic [1:0] len_code;

   // cnt saturates at 33, so only multiples of 8 in 8..32 are good lengths
   assign frame_end = (state_q == RECV) && !bus.si_valid;
   assign len_ok    = (cnt_q[2:0] == 3'd0) && (cnt_q >= 6'd8) && (cnt_q <= 6'd32);
   assign len_code  = cnt_q[4:3] - 2'd1;
   assign pop       = bus.rd_valid && bus.rd_ready;
   assign push      = frame_end && len_ok && ((level_q != FULL_LVL) || pop);

   assign bus.rd_valid = (level_q != '0);
   assign bus.rd_word  = bus.rd_valid ? mem_q[rd_ptr_q][31:0]  : 32'd0;
   assign bus.rd_len   = bus.rd_valid ? mem_q[rd_ptr_q][33:32] : 2'd0;
   assign err_len      = err_len_q;
   assign overflow     = overflow_q;
   assign level        = level_q;
   assign dbg_recv_o   = (state_q == RECV);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         err_len_q  <= 1'b0;
         overflow_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         err_len_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.si_valid) begin
                  shift_q <= {31'd0, bus.si_data};
                  cnt_q   <= 6'd1;
                  state_q <= RECV;
               end
            end
            RECV: begin
               if (bus.si_valid) begin
                  if (cnt_q < 6'd32) shift_q[cnt_q[4:0]] <= bus.si_data;
                  if (cnt_q != 6'd33) cnt_q <= cnt_q + 6'd1;
               end else begin
                  state_q   <= IDLE;
                  cnt_q     <= '0;
                  err_len_q <= !len_ok;
                  if (len_ok && !push) overflow_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (push) begin
            mem_q[wr_ptr_q] <= {len_code, shift_q};
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         // a simultaneous push and pop leaves the occupancy unchanged
         if (push && !pop)      level_q <= level_q + LW'(1);
         else if (pop && !push) level_q <= level_q - LW'(1);
      end
   end
endmodule

// File: tb/tb_sti_deserializer.sv
// Bench for sti_deserializer: drives serial frames and checks the FIFO
// read side against a queue-based model of the frame/length rules.
module tb_sti_deserializer;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          err_len;
   logic          overflow;
   logic [LW-1:0] level;
   logic          dbg_recv;

   sti_deserializer_if bus();

   sti_deserializer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .err_len    (err_len),
      .overflow   (overflow),
      .level      (level),
      .dbg_recv_o (dbg_recv)
   );

   always #5 clk = ~clk;

   logic [33:0] exp_q[$];
   bit          exp_ovf;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive n bits LSB-first, then leave si_valid low for the frame-end edge.
   task automatic send_bits(input logic [63:0] data, input int n);
      for (int i = 0; i < n; i++) begin
         bus.si_valid = 1'b1;
         bus.si_data  = data[i];
         tick();
      end
      bus.si_valid = 1'b0;
      bus.si_data  = 1'($urandom);
   endtask

   // Model of one frame-end edge; returns the expected err_len pulse.
   function automatic bit model_frame_end(input logic [63:0] data, input int n, input bit pop);
      logic [31:0] word;
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (!(n == 8 || n == 16 || n == 24 || n == 32)) return 1'b1;
      word = 32'(data & ((64'd1 << n) - 64'd1));
      if (exp_q.size() < DEPTH) exp_q.push_back({2'(n / 8 - 1), word});
      else exp_ovf = 1'b1;
      return 1'b0;
   endfunction

   task automatic test_reset();
      n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
      n_checks++; if (bus.rd_word !== 32'd0) begin n_fail++; $display("FAIL reset_rd_word: got %h expected 0", bus.rd_word); end
      n_checks++; if (bus.rd_len !== 2'd0) begin n_fail++; $display("FAIL reset_rd_len: got %0d expected 0", bus.rd_len); end
      n_checks++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL reset_err_len: got %b expected 0", err_len); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      n_checks++; if (level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
      n_checks++; if (dbg_recv !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b expected 0", dbg_recv); end
   endtask

   task automatic test_8bit();
      bit e;
      send_bits(64'hA5, 8);
      n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL b8_early_valid: got %b expected 0", bus.rd_valid); end
      tick();
      e = model_frame_end(64'hA5, 8, 1'b0);
      n_checks++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL b8_valid: got %b expected 1", bus.rd_valid); end
      n_checks++; if (bus.rd_word !== 32'h0000_00A5 || bus.rd_word !== exp_q[0][31:0]) begin n_fail++; $display("FAIL b8_word: got %h expected 000000a5", bus.rd_word); end
      n_checks++; if (bus.rd_len !== exp_q[0][33:32]) begin n_fail++; $display("FAIL b8_len: got %0d expected %0d", bus.rd_len, exp_q[0][33:32]); end
      n_checks++; if (level !== LW'(exp_q.size())) begin n_fail++; $display("FAIL b8_level: got %0d expected %0d", level, exp_q.size()); end
      n_checks++; if (err_len !== e) begin n_fail++; $display("FAIL b8_err: got %b expected %b", err_len, e); end
      bus.rd_ready = 1'b1;
      tick();
      bus.rd_ready = 1'b0;
      void'(exp_q.pop_front());
      n_checks++; if (bus.rd_valid !== 1'b0 || level !== '0) begin n_fail++; $display("FAIL b8_pop: got valid=%b level=%0d expected 0 0", bus.rd_valid, level); end
      n_checks++; if (bus.rd_word !== 32'd0 || bus.rd_len !== 2'd0) begin n_fail++; $display("FAIL b8_gated: got %h/%0d expected 0/0", bus.rd_word, bus.rd_len); end
   endtask

   task automatic test_len32_24();
      logic [63:0] d [2];
      int          n [2];
      logic [31:0] w [2];
      logic [1:0]  l [2];
      bit          e;
      d[0] = 64'hDEAD_BEEF; n[0] = 32; w[0] = 32'hDEAD_BEEF; l[0] = 2'd3;
      d[1] = 64'h12_3456;   n[1] = 24; w[1] = 32'h0012_3456; l[1] = 2'd2;
      for (int k = 0; k < 2; k++) begin
         send_bits(d[k], n[k]);
         tick();
         e = model_frame_end(d[k], n[k], 1'b0);
         n_checks++; if (bus.rd_word !== w[k] || bus.rd_word !== exp_q[0][31:0]) begin n_fail++; $display("FAIL long_word%0d: got %h expected %h", k, bus.rd_word, w[k]); end
         n_checks++; if (bus.rd_len !== l[k]) begin n_fail++; $display("FAIL long_len%0d: got %0d expected %0d", k, bus.rd_len, l[k]); end
         n_checks++; if (err_len !== e) begin n_fail++; $display("FAIL long_err%0d: got %b expected %b", k, err_len, e); end
         bus.rd_ready = 1'b1;
         tick();
         bus.rd_ready = 1'b0;
         void'(exp_q.pop_front());
         n_checks++; if (level !== '0) begin n_fail++; $display("FAIL long_drain%0d: got level %0d expected 0", k, level); end
      end
   endtask

   task automatic test_bad_len();
      int          lens [2];
      logic [63:0] d;
      int          n;
      bit          e;
      lens[0] = 12; lens[1] = 40;
      for (int k = 0; k < 2; k++) begin
         d = {$urandom, $urandom};
         send_bits(d, lens[k]);
         tick();
         e = model_frame_end(d, lens[k], 1'b0);
         n_checks++; if (err_len !== e) begin n_fail++; $display("FAIL bad_err%0d: got %b expected %b", lens[k], err_len, e); end
         tick();
         n_checks++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL bad_pulse%0d: got %b expected 0", lens[k], err_len); end
         n_checks++; if (level !== '0 || overflow !== 1'b0) begin n_fail++; $display("FAIL bad_state%0d: got level=%0d ovf=%b expected 0 0", lens[k], level, overflow); end
      end
      for (int k = 0; k < 8; k++) begin
         d = {$urandom, $urandom};
         n = (k % 2 == 0) ? 8 * $urandom_range(1, 4) : $urandom_range(1, 40);
         send_bits(d, n);
         tick();
         e = model_frame_end(d, n, 1'b0);
         n_checks++; if (err_len !== e) begin n_fail++; $display("FAIL rnd_err n=%0d: got %b expected %b", n, err_len, e); end
         n_checks++; if (level !== LW'(exp_q.size())) begin n_fail++; $display("FAIL rnd_level n=%0d: got %0d expected %0d", n, level, exp_q.size()); end
         if (exp_q.size() > 0) begin
            n_checks++; if (bus.rd_word !== exp_q[0][31:0] || bus.rd_len !== exp_q[0][33:32]) begin n_fail++; $display("FAIL rnd_head n=%0d: got %h/%0d expected %h/%0d", n, bus.rd_word, bus.rd_len, exp_q[0][31:0], exp_q[0][33:32]); end
            bus.rd_ready = 1'b1;
            tick();
            bus.rd_ready = 1'b0;
            void'(exp_q.pop_front());
         end
      end
   endtask

   task automatic test_full();
      bit e;
      for (int k = 1; k <= 5; k++) begin
         send_bits(64'(k), 16);
         tick();
         e = model_frame_end(64'(k), 16, 1'b0);
      end
      n_checks++; if (level !== 3'd4 || level !== LW'(exp_q.size())) begin n_fail++; $display("FAIL full_level: got %0d expected 4", level); end
      n_checks++; if (overflow !== 1'b1 || overflow !== exp_ovf) begin n_fail++; $display("FAIL full_overflow: got %b expected 1", overflow); end
      for (int k = 1; k <= 4; k++) begin
         n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_word !== 32'(k) || bus.rd_word !== exp_q[0][31:0] || bus.rd_len !== 2'd1) begin n_fail++; $display("FAIL full_drain%0d: got v=%b %h/%0d expected 1 %h/1", k, bus.rd_valid, bus.rd_word, bus.rd_len, 32'(k)); end
         bus.rd_ready = 1'b1;
         tick();
         bus.rd_ready = 1'b0;
         void'(exp_q.pop_front());
      end
      n_checks++; if (level !== '0 || overflow !== 1'b1) begin n_fail++; $display("FAIL full_after: got level=%0d ovf=%b expected 0 1", level, overflow); end
   endtask

   task automatic test_reset_mid_frame();
      logic [63:0] d;
      bit          e;
      d = 64'($urandom);
      send_bits(d, 8);
      tick();
      e = model_frame_end(d, 8, 1'b0);
      for (int i = 0; i < 5; i++) begin
         bus.si_valid = 1'b1;
         bus.si_data  = 1'($urandom);
         tick();
      end
      reset = 1'b1;
      bus.si_valid = 1'b0;
      #1;
      exp_q.delete();
      exp_ovf = 1'b0;
      n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_word !== 32'd0 || bus.rd_len !== 2'd0) begin n_fail++; $display("FAIL rst_mid_head: got v=%b %h/%0d expected 0", bus.rd_valid, bus.rd_word, bus.rd_len); end
      n_checks++; if (level !== '0 || overflow !== 1'b0 || err_len !== 1'b0 || dbg_recv !== 1'b0) begin n_fail++; $display("FAIL rst_mid_status: got level=%0d ovf=%b err=%b recv=%b expected 0", level, overflow, err_len, dbg_recv); end
      tick();
      tick();
      reset = 1'b0;
      tick();
      n_checks++; if (level !== '0 || bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_nocommit: got level=%0d expected 0", level); end
      send_bits(64'h3C, 8);
      tick();
      e = model_frame_end(64'h3C, 8, 1'b0);
      n_checks++; if (bus.rd_word !== 32'h3C || bus.rd_word !== exp_q[0][31:0] || bus.rd_len !== 2'd0 || level !== 3'd1) begin n_fail++; $display("FAIL rst_mid_3c: got %h/%0d level=%0d expected 0000003c/0 1", bus.rd_word, bus.rd_len, level); end
      bus.rd_ready = 1'b1;
      tick();
      bus.rd_ready = 1'b0;
      void'(exp_q.pop_front());
   endtask

   task automatic test_push_pop_full();
      logic [63:0] d;
      logic [31:0] last;
      bit          e;
      for (int k = 0; k < 4; k++) begin
         d = 64'($urandom);
         send_bits(d, 16);
         tick();
         e = model_frame_end(d, 16, 1'b0);
      end
      send_bits(64'h7E, 8);
      n_checks++; if (level !== 3'd4 || bus.rd_word !== exp_q[0][31:0]) begin n_fail++; $display("FAIL pp_before: got level=%0d head=%h expected 4 %h", level, bus.rd_word, exp_q[0][31:0]); end
      bus.rd_ready = 1'b1;
      tick();
      bus.rd_ready = 1'b0;
      e = model_frame_end(64'h7E, 8, 1'b1);
      n_checks++; if (level !== 3'd4 || level !== LW'(exp_q.size())) begin n_fail++; $display("FAIL pp_level: got %0d expected 4", level); end
      n_checks++; if (overflow !== 1'b0 || err_len !== e) begin n_fail++; $display("FAIL pp_flags: got ovf=%b err=%b expected 0 0", overflow, err_len); end
      last = 32'd0;
      while (exp_q.size() > 0) begin
         n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_word !== exp_q[0][31:0] || bus.rd_len !== exp_q[0][33:32]) begin n_fail++; $display("FAIL pp_drain: got v=%b %h/%0d expected 1 %h/%0d", bus.rd_valid, bus.rd_word, bus.rd_len, exp_q[0][31:0], exp_q[0][33:32]); end
         last = bus.rd_word;
         bus.rd_ready = 1'b1;
         tick();
         bus.rd_ready = 1'b0;
         void'(exp_q.pop_front());
      end
      n_checks++; if (last !== 32'h7E || level !== '0) begin n_fail++; $display("FAIL pp_last: got %h level=%0d expected 0000007e 0", last, level); end
   endtask

   task automatic test_wrap();
      logic [63:0] d;
      int          n;
      bit          e;
      for (int k = 0; k < 12; k++) begin
         d = {$urandom, $urandom};
         n = 8 * $urandom_range(1, 4);
         send_bits(d, n);
         tick();
         e = model_frame_end(d, n, 1'b0);
         n_checks++; if (err_len !== e || level !== LW'(exp_q.size())) begin n_fail++; $display("FAIL wrap_push%0d: got err=%b level=%0d expected %b %0d", k, err_len, level, e, exp_q.size()); end
         if (k >= 2) begin
            n_checks++; if (bus.rd_word !== exp_q[0][31:0] || bus.rd_len !== exp_q[0][33:32]) begin n_fail++; $display("FAIL wrap_pop%0d: got %h/%0d expected %h/%0d", k, bus.rd_word, bus.rd_len, exp_q[0][31:0], exp_q[0][33:32]); end
            bus.rd_ready = 1'b1;
            tick();
            bus.rd_ready = 1'b0;
            void'(exp_q.pop_front());
         end
      end
      while (exp_q.size() > 0) begin
         n_checks++; if (bus.rd_word !== exp_q[0][31:0] || bus.rd_len !== exp_q[0][33:32]) begin n_fail++; $display("FAIL wrap_drain: got %h/%0d expected %h/%0d", bus.rd_word, bus.rd_len, exp_q[0][31:0], exp_q[0][33:32]); end
         bus.rd_ready = 1'b1;
         tick();
         bus.rd_ready = 1'b0;
         void'(exp_q.pop_front());
      end
      n_checks++; if (level !== '0 || bus.rd_valid !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_end: got level=%0d v=%b ovf=%b expected 0 0 0", level, bus.rd_valid, overflow); end
   endtask

   initial begin
      bus.si_data  = 1'b0;
      bus.si_valid = 1'b0;
      bus.rd_ready = 1'b0;
      exp_ovf      = 1'b0;
      reset        = 1'b1;
      tick();
      test_reset();
      tick();
      reset = 1'b0;
      tick();
      test_reset();
      test_8bit();
      test_len32_24();
      test_bad_len();
      test_full();
      test_reset_mid_frame();
      test_push_pop_full();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
